// File: rtl/cp0_unit.sv
// Coprocessor-0 exception controller: SR, Cause, EPC and PRId registers,
// interrupt/exception detection for the M-stage instruction, eret and mtc0/mfc0.
module cp0_unit #(
  parameter logic [31:0] PRID    = 32'h0000_2000,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        irq,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im_q,    sr_im_d;
  logic        sr_exl_q,   sr_exl_d;
  logic        sr_ie_q,    sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,      epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] victim_pc;

  assign sr_val    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
  assign cause_val = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
  assign victim_pc = {pc[31:2], 2'b00};

  // Request detection and the combinational outputs; EXL masks everything so
  // faults taken inside the handler are dropped rather than nested.
  always_comb begin
    int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req = (exc_code != 5'd0) & ~sr_exl_q;
    irq     = int_req | exc_req;
    epc_out = irq ? HANDLER : epc_q;
    unique case (addr)
      ADDR_SR:    dout = sr_val;
      ADDR_CAUSE: dout = cause_val;
      ADDR_EPC:   dout = epc_q;
      ADDR_PRID:  dout = PRID;
      default:    dout = 32'd0;
    endcase
  end

  // Next-state: exception entry wins over eret, eret wins over mtc0.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (irq) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd;
      cause_exc_d = int_req ? 5'd0 : exc_code;
      epc_d       = bd ? (victim_pc - 32'd4) : victim_pc;
    end else if (eret) begin
      sr_exl_d = 1'b0;
    end else if (we) begin
      unique case (addr)
        ADDR_SR: begin
          sr_im_d  = din[15:10];
          sr_exl_d = din[1];
          sr_ie_d  = din[0];
        end
        ADDR_CAUSE: cause_exc_d = din[6:2];
        ADDR_EPC:   epc_d       = {din[31:2], 2'b00};
        default:    ;
      endcase
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with hand-computed expectations.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic        irq;
  logic [31:0] epc_out;

  int checks   = 0;
  int failures = 0;

  cp0_unit dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .we       (we),
    .din      (din),
    .dout     (dout),
    .pc       (pc),
    .bd       (bd),
    .exc_code (exc_code),
    .hw_int   (hw_int),
    .eret     (eret),
    .irq      (irq),
    .epc_out  (epc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, landing 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    step();
    we = 1'b0; din = 32'd0;
  endtask

  initial begin
    reset = 1'b1; addr = 5'd0; we = 1'b0; din = 32'd0; pc = 32'd0;
    bd = 1'b0; exc_code = 5'd0; hw_int = 6'd0; eret = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h0000_2000);
    rd("rst_other", 5'd3, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    rd("sr_write", 5'd12, 32'h0000_0401);
    hw_int = 6'b000001; pc = 32'h3008; bd = 1'b0;
    #1;
    check("int_irq", {31'd0, irq}, 32'd1);
    check("int_epc_out", epc_out, 32'h0000_4180);
    step();
    check("int_irq_drop", {31'd0, irq}, 32'd0);
    rd("int_epc", 5'd14, 32'h0000_3008);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);

    // eret returns to EPC and clears EXL
    hw_int = 6'd0; eret = 1'b1;
    #1;
    check("eret1_irq", {31'd0, irq}, 32'd0);
    check("eret1_epc_out", epc_out, 32'h0000_3008);
    step();
    eret = 1'b0;
    rd("eret1_sr", 5'd12, 32'h0000_0401);

    // Synchronous exception in a delay slot
    mtc0(5'd12, 32'h0);
    exc_code = 5'd10; pc = 32'h3014; bd = 1'b1;
    #1;
    check("exc_irq", {31'd0, irq}, 32'd1);
    step();
    exc_code = 5'd0; bd = 1'b0;
    rd("exc_epc", 5'd14, 32'h0000_3010);
    rd("exc_cause", 5'd13, 32'h8000_0028);
    rd("exc_sr", 5'd12, 32'h0000_0002);

    // EXL masks nested requests
    exc_code = 5'd4; hw_int = 6'h3F;
    #1;
    check("nest_irq", {31'd0, irq}, 32'd0);
    step();
    rd("nest_cause", 5'd13, 32'h8000_FC28);
    rd("nest_epc", 5'd14, 32'h0000_3010);
    exc_code = 5'd0; hw_int = 6'd0; eret = 1'b1;
    #1;
    check("eret2_epc_out", epc_out, 32'h0000_3010);
    step();
    eret = 1'b0;
    rd("eret2_sr", 5'd12, 32'h0);

    // Interrupt beats simultaneous exception; mtc0 is discarded
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001; exc_code = 5'd12; pc = 32'h5000; bd = 1'b0;
    addr = 5'd14; din = 32'hABCD_0000; we = 1'b1;
    #1;
    check("prio_irq", {31'd0, irq}, 32'd1);
    step();
    we = 1'b0; din = 32'd0; exc_code = 5'd0; hw_int = 6'd0;
    rd("prio_epc", 5'd14, 32'h0000_5000);
    rd("prio_cause", 5'd13, 32'h0000_0400);
    eret = 1'b1;
    step();
    eret = 1'b0;

    // Cause write touches only ExcCode
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_write", 5'd13, 32'h0000_007C);

    // mfc0 EPC alongside an mtc0 EPC write sees the old value
    addr = 5'd14; din = 32'h0000_3003; we = 1'b1;
    #1;
    check("epc_nobypass", dout, 32'h0000_5000);
    step();
    we = 1'b0;
    rd("epc_align", 5'd14, 32'h0000_3000);

    // Masked line: IP follows hw_int, no irq
    mtc0(5'd12, 32'h0000_0001);
    hw_int = 6'b100000;
    #1;
    check("masked_irq", {31'd0, irq}, 32'd0);
    step();
    rd("masked_cause", 5'd13, 32'h0000_807C);

    // Reset inside the handler
    hw_int = 6'd0;
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001; pc = 32'h3017;
    step();
    rd("unaligned_epc", 5'd14, 32'h0000_3014);
    rd("handler_sr", 5'd12, 32'h0000_0403);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd("rst2_sr", 5'd12, 32'h0);
    rd("rst2_cause", 5'd13, 32'h0);
    check("rst2_irq", {31'd0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 / exception controller for the 5-stage MIPS pipeline.
- Holds SR, Cause, EPC and PRId. Detects interrupts and exceptions on the instruction in the M stage and generates the `irq` flush/redirect signal.
- `irq` is the signal the multiply/divide unit uses to cancel a start.
- Also services `mtc0`, `mfc0` and `eret`.

Parameters:
- PRID, 32'h0000_2000, read-only processor ID value returned for register 15.
- HANDLER, 32'h0000_4180, exception entry PC driven on epc_out while irq is high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  5  CP0 register number for mtc0/mfc0 (12 SR, 13 Cause, 14 EPC, 15 PRId)
- we  in  1  mtc0 write enable (M stage)
- din  in  32  mtc0 write data (GPR rt)
- dout  out  32  mfc0 read data, combinational from addr
- pc  in  32  PC of the instruction currently in M (victim PC)
- bd  in  1  M-stage instruction is in a branch delay slot
- exc_code  in  5  synchronous exception code for the M instruction; 0 = none
- hw_int  in  6  external interrupt lines, level-sensitive
- eret  in  1  eret in M stage
- irq  out  1  take-exception pulse; flushes pipeline, redirects fetch to HANDLER
- epc_out  out  32  HANDLER when irq=1, else EPC register (eret target)

Behaviour:
- Reset: SR=0, Cause=0, EPC=0. After reset, irq=0 and dout=0 for addr≠15.
- Register fields (unlisted bits read 0, writes ignored):
  - SR: IM[15:10], EXL[1], IE[0].
  - Cause: BD[31], IP[15:10] (read-only), ExcCode[6:2].
  - EPC: 32-bit.
  - PRId: read-only.
- dout is combinational:
  - addr 12 → SR, 13 → Cause, 14 → EPC, 15 → PRID.
  - Any other addr → 0.
- Interrupt pending: int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- Exception pending: exc_req = (exc_code≠0) & ~SR.EXL.
- irq = int_req | exc_req, combinational, same cycle.
- Cause.IP <= hw_int every cycle that reset is low, regardless of other events.
- On a clock edge with irq=1:
  - SR.EXL <= 1.
  - Cause.BD <= bd.
  - Cause.ExcCode <= 0 if int_req, else exc_code. Interrupt has priority over a simultaneous exception.
  - EPC <= {pc[31:2],2'b00} - 4 if bd, else {pc[31:2],2'b00}.
  - A simultaneous we or eret is ignored; the M instruction is cancelled.
- On a clock edge with irq=0 and eret=1: SR.EXL <= 0. A simultaneous we is ignored.
- On a clock edge with irq=0, eret=0 and we=1:
  - addr 12: SR.IM/EXL/IE <= din fields.
  - addr 13: Cause.ExcCode <= din[6:2] only. BD and IP are not writable.
  - addr 14: EPC <= {din[31:2],2'b00}.
  - addr 15 or other: no effect.
- Priority per edge: reset > exception entry > eret > mtc0.
- Nesting: while EXL=1, irq never asserts, even with exc_code≠0. Exceptions inside the handler are dropped.
- irq lasts exactly the cycles its condition holds. After entry, EXL=1 forces irq low on the next cycle.
- mfc0 EPC in the same cycle as an mtc0 EPC write returns the old value. There is no internal bypass.
- Reset mid-handler clears EXL, so interrupts are blocked until software sets IE.

Test Plan:
- Reset, then read addr 12/13/14/15 → dout = 0, 0, 0, 32'h2000; irq=0.
- mtc0 SR=32'h0000_0401 (IM[10], IE); hw_int=6'b000001; pc=32'h3008, bd=0:
  - irq=1 same cycle, epc_out=32'h4180.
  - Next cycle: EPC=32'h3008, Cause.ExcCode=0, SR.EXL=1, irq=0.
- EXL=0, IE=0, exc_code=5'd10, pc=32'h3014, bd=1:
  - irq=1.
  - Next cycle: EPC=32'h3010, Cause=32'h8000_0028 (BD, ExcCode=10), EXL=1.
- With EXL=1: exc_code=4 and hw_int=6'h3F → irq stays 0. Then eret → EXL=0, epc_out=EPC before the edge.
- Same cycle: int_req and exc_code=12 and we=1 to EPC → ExcCode=0, EPC=victim PC, mtc0 discarded.
- mtc0 EPC=32'h0000_3003 → EPC reads 32'h3000. Then hw_int=6'b100000 with IM=0 → Cause.IP=6'b100000, irq=0.
